// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   ctr_t       : 2-bit saturating branch-history counter encoding
//   CTR_RESET   : value every history entry takes on reset
//   ctr_next()  : saturating step toward taken (dir=1) or not-taken (dir=0)
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    function automatic ctr_t ctr_next(input ctr_t c, input logic dir);
        logic [1:0] v;
        v = c;
        if (dir && v != 2'd3) begin
            v = v + 2'd1;
        end else if (!dir && v != 2'd0) begin
            v = v - 2'd1;
        end
        return ctr_t'(v);
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of 2-bit saturating counters indexed by PC bits.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx / rd_ctr   : combinational read port
//   upd_en, upd_idx,
//   upd_dir           : synchronous update, dir=1 steps toward taken
module branch_history_table
    import bp_pkg::*;
#(
    parameter int unsigned entries = 16,
    localparam int unsigned iw = $clog2(entries)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [iw-1:0] rd_idx,
    output ctr_t          rd_ctr,
    input  logic          upd_en,
    input  logic [iw-1:0] upd_idx,
    input  logic          upd_dir
);

    ctr_t table_q [entries];

    // No bypass: a same-cycle update is visible only after the edge.
    assign rd_ctr = table_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < entries; i++) begin
                table_q[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            table_q[upd_idx] <= ctr_next(table_q[upd_idx], upd_dir);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction and resolution unit for the 5-stage pipeline.
// Predicts for the IF-stage PC from the history table and resolves BEQ/BNE
// in ID from the operand-equality bit; a mispredict raises a registered
// one-cycle flush with the corrected fetch PC and trains the table.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   if_pc / pred_taken        : IF PC and its combinational prediction
//   id_valid, id_stall        : ID instruction valid / ID held by hazard
//   id_is_beq, id_is_bne      : branch type (both set = not a branch)
//   id_equal                  : ID operand-equality result
//   id_pred_taken             : prediction carried with the ID instruction
//   id_pc, id_target,
//   id_pc_plus4               : branch PC, taken target, fall-through
//   flush, redirect_pc        : one-cycle squash pulse and fetch PC
//   branch_count,
//   mispredict_count          : saturating statistics
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned width     = 32,
    parameter int unsigned entries   = 16,
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     if_pc,
    output logic                 pred_taken,
    input  logic                 id_valid,
    input  logic                 id_stall,
    input  logic                 id_is_beq,
    input  logic                 id_is_bne,
    input  logic                 id_equal,
    input  logic                 id_pred_taken,
    input  logic [width-1:0]     id_pc,
    input  logic [width-1:0]     id_target,
    input  logic [width-1:0]     id_pc_plus4,
    output logic                 flush,
    output logic [width-1:0]     redirect_pc,
    output logic [cnt_width-1:0] branch_count,
    output logic [cnt_width-1:0] mispredict_count
);

    localparam int unsigned iw = $clog2(entries);
    localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

    ctr_t          if_ctr;
    logic [iw-1:0] if_idx;
    logic [iw-1:0] id_idx;
    logic          resolve;
    logic          taken;
    logic          mispredict;

    assign if_idx = if_pc[iw+1:2];
    assign id_idx = id_pc[iw+1:2];

    // While flush is high the ID slot holds a wrong-path instruction.
    assign resolve    = id_valid & ~id_stall & ~flush & (id_is_beq ^ id_is_bne);
    assign taken      = (id_is_beq & id_equal) | (id_is_bne & ~id_equal);
    assign mispredict = taken ^ id_pred_taken;

    assign pred_taken = if_ctr[1];

    branch_history_table #(
        .entries (entries)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (if_idx),
        .rd_ctr  (if_ctr),
        .upd_en  (resolve),
        .upd_idx (id_idx),
        .upd_dir (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            flush            <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            flush <= resolve & mispredict;
            if (resolve & mispredict) begin
                redirect_pc <= taken ? id_target : id_pc_plus4;
            end
            if (resolve && branch_count != '1) begin
                branch_count <= branch_count + cnt_one;
            end
            if (resolve && mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + cnt_one;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{if_pc[width-1:iw+2], if_pc[1:0],
                           id_pc[width-1:iw+2], id_pc[1:0], if_ctr[0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        id_valid, id_stall, id_is_beq, id_is_bne, id_equal, id_pred_taken;
    logic [31:0] id_pc, id_target, id_pc_plus4;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    branch_predictor #(
        .width     (32),
        .entries   (16),
        .cnt_width (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .id_valid         (id_valid),
        .id_stall         (id_stall),
        .id_is_beq        (id_is_beq),
        .id_is_bne        (id_is_bne),
        .id_equal         (id_equal),
        .id_pred_taken    (id_pred_taken),
        .id_pc            (id_pc),
        .id_target        (id_target),
        .id_pc_plus4      (id_pc_plus4),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        f;
        logic [31:0] r;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_tab [16];
    logic        m_known = 1'b0;
    logic        m_flush = 1'b0;
    logic [31:0] m_redir = '0;
    int          m_bc = 0;
    int          m_mc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_br(input logic v, input logic st, input logic beq, input logic bne,
                            input logic eq, input logic pt, input logic [31:0] pc,
                            input logic [31:0] tgt);
        id_valid      = v;
        id_stall      = st;
        id_is_beq     = beq;
        id_is_bne     = bne;
        id_equal      = eq;
        id_pred_taken = pt;
        id_pc         = pc;
        id_target     = tgt;
        id_pc_plus4   = pc + 32'd4;
    endtask

    task automatic idle();
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // One clock: check the combinational prediction, advance the model and
    // queue its post-edge expectation, then compare after the edge.
    task automatic cycle();
        logic res, tk, mis;
        int   i;
        exp_t e, got;
        #1;
        if (m_known) begin
            chk("pred_taken", {63'd0, pred_taken}, {63'd0, m_tab[(if_pc >> 2) & 15] >= 2});
        end
        res = id_valid && !id_stall && !m_flush && (id_is_beq != id_is_bne);
        tk  = (id_is_beq && id_equal) || (id_is_bne && !id_equal);
        mis = (tk != id_pred_taken);
        if (rst) begin
            for (int k = 0; k < 16; k++) m_tab[k] = 1;
            m_known = 1'b1;
            m_flush = 1'b0;
            m_redir = '0;
            m_bc = 0;
            m_mc = 0;
        end else begin
            m_flush = res && mis;
            if (res && mis) m_redir = tk ? id_target : id_pc_plus4;
            if (res) begin
                i = (id_pc >> 2) & 15;
                if (tk && m_tab[i] < 3) m_tab[i]++;
                if (!tk && m_tab[i] > 0) m_tab[i]--;
                if (m_bc < 65535) m_bc++;
                if (mis && m_mc < 65535) m_mc++;
            end
        end
        e.f  = m_flush;
        e.r  = m_redir;
        e.bc = 16'(m_bc);
        e.mc = 16'(m_mc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        if (m_known) begin
            chk("flush", {63'd0, flush}, {63'd0, got.f});
            if (got.f) chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, got.r});
            chk("branch_count", {48'd0, branch_count}, {48'd0, got.bc});
            chk("mispredict_count", {48'd0, mispredict_count}, {48'd0, got.mc});
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        if_pc = 32'h0;
        idle();
        cycle();
        chk("reset redirect_pc", {32'd0, redirect_pc}, 64'd0);
        rst = 1'b0;

        // All 16 entries predict not-taken after reset
        for (int unsigned a = 0; a <= 32'h3C; a += 4) begin
            if_pc = a;
            cycle();
        end

        // BEQ taken, predicted not-taken: flush to target
        drive_br(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h80);
        cycle();
        idle();
        cycle();   // flush cycle
        cycle();   // flush back low
        if_pc = 32'h10;
        cycle();   // entry now WT -> predicts taken

        // BNE not taken, predicted not-taken: four times, saturates at SNT
        for (int n = 0; n < 4; n++) begin
            drive_br(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h100);
            cycle();
        end
        idle();
        if_pc = 32'h20;
        cycle();

        // Mispredict held through the flush cycle: resolves once only
        drive_br(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h200);
        cycle();
        cycle();
        // Same branch stalled for 3 cycles, then released for one
        drive_br(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h34, 32'h300);
        repeat (3) cycle();
        id_stall = 1'b0;
        cycle();
        idle();
        cycle();
        cycle();

        // Not-taken mispredict: redirect to fall-through
        drive_br(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3C, 32'h400);
        cycle();
        idle();
        cycle();

        // Reset coincident with a mispredict: no flush, everything cleared
        drive_br(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h500);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        // Reset while a flush is pending
        drive_br(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 32'h600);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int unsigned a = 0; a <= 32'h3C; a += 4) begin
            if_pc = a;
            cycle();
        end

        // Both branch flags set: not a branch, ignored
        drive_br(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h18, 32'h700);
        cycle();
        idle();
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            drive_br(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     {26'd0, 4'($urandom), 2'b00}, $urandom & 32'hFFFF_FFFC);
            if_pc = {26'd0, 4'($urandom), 2'b00};
            cycle();
        end
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch prediction and resolution unit for the 5-stage pipeline. It gives the IF stage a taken/not-taken prediction from a 2-bit saturating-counter history table, and consumes the ID-stage operand-equality result to resolve BEQ/BNE. On a misprediction it issues a registered flush/redirect and trains the table. It is the consumer end of the ID-stage equality compare: it turns the compare bit into control flow.

## Interface
- width, 32, PC and target width
- entries, 16, history-table entries (power of 2, ≥2)
- cnt_width, 16, width of each statistics counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  width  PC currently in IF
- pred_taken  out  1  prediction for if_pc (combinational table read)
- id_valid  in  1  ID holds a valid instruction this cycle
- id_stall  in  1  ID is stalled (hazard); resolution suppressed
- id_is_beq  in  1  ID instruction is BEQ
- id_is_bne  in  1  ID instruction is BNE
- id_equal  in  1  ID operand-equality result
- id_pred_taken  in  1  prediction carried down with the ID instruction
- id_pc  in  width  PC of the ID instruction
- id_target  in  width  branch target
- id_pc_plus4  in  width  fall-through PC
- flush  out  1  registered one-cycle squash/redirect pulse
- redirect_pc  out  width  PC to fetch when flush=1
- branch_count  out  cnt_width  resolved branches, saturating
- mispredict_count  out  cnt_width  mispredictions, saturating

## Operation
- Index: idx = pc[log2(entries)+1:2], used for both read (if_pc) and update (id_pc).
- Counter states: SNT=0, WNT=1, WT=2, ST=3. pred_taken = counter[1].
- A resolution happens in a cycle when id_valid & ~id_stall & ~flush & (id_is_beq ^ id_is_bne).
  - If id_is_beq and id_is_bne are both set, the instruction is not a branch: no update, no flush.
- Outcome: taken = (id_is_beq & id_equal) | (id_is_bne & ~id_equal).
- Table update on resolution: taken increments the counter, saturating at 3; not-taken decrements it, saturating at 0.
- Mispredict = taken ≠ id_pred_taken. On mispredict, the next cycle has flush=1 and redirect_pc = taken ? id_target : id_pc_plus4.
- branch_count increments on every resolution. mispredict_count increments on every mispredict. Both hold at all-ones.

## Timing
- Reset (synchronous): all counters → WNT, flush=0, redirect_pc=0, both statistics counters = 0.
  - Reset asserted while a flush is pending cancels that flush; flush=0 on the cycle after reset.
- Prediction latency is 0: pred_taken follows if_pc combinationally from the current table.
- Resolution at edge N sets flush/redirect_pc valid during cycle N+1, for exactly one cycle. Table and statistics update at the same edge N.
- While flush=1, the ID contents are wrong-path: no resolution, no update, no second flush.
- Read and update of the same index in one cycle: pred_taken shows the pre-update value (no bypass).
- While id_stall=1, the unit takes no action. The held branch resolves once, on the first unstalled cycle.
- Back-to-back correct predictions produce no flush. Consecutive mispredicts are at least two cycles apart, because of the flush-cycle suppression.

## Structure
- Shared package `bp_pkg`: counter encodings SNT/WNT/WT/ST, reset value WNT, and a saturating increment/decrement function.
- Sub-module `branch_history_table`:
  - parameterized entries × 2-bit counter array
  - one combinational read port
  - one synchronous update port (idx, dir, en)
  - synchronous reset to WNT
- The top level holds the outcome logic, the flush/redirect registers and the statistics counters.

## Test plan
- Reset, then sweep if_pc over 0x00–0x3C: pred_taken=0 for all 16 entries. Both counters and flush read 0.
- BEQ at id_pc=0x10, id_equal=1, id_pred_taken=0, id_target=0x80: next cycle flush=1, redirect_pc=0x80, mispredict_count=1. The cycle after that, flush=0. if_pc=0x10 now predicts 1 (WT).
- BNE at 0x20, id_equal=1 (not taken), id_pred_taken=0: no flush, branch_count increments. Three more not-taken resolutions: the counter saturates at 0, with no underflow.
- Hold id_valid=1 with a mispredicting branch in the cycle after a flush: no second flush and no count change. Repeat under id_stall=1 for 3 cycles, then release: exactly one resolution occurs.
- Assert rst in the cycle flush would rise: flush stays 0, table returns to WNT, counters are 0. Set id_is_beq=id_is_bne=1: ignored.
